// File: rtl/fir_coeff_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_loader_if
// Purpose  : Control, data and status bundle between the coefficient loader
//            and whatever drives it.
// Revision : 1.0
// ============================================================================
interface fir_coeff_loader_if #(
  parameter int NUM_TAPS = 4,
  parameter int COEFF_W  = 8
);
  logic                          ena;
  logic                          set_coeffs;
  logic                          din_valid;
  logic [COEFF_W-1:0]            din;
  logic [NUM_TAPS*COEFF_W-1:0]   coeff_flat;
  logic                          coeff_update;
  logic                          loading;
  logic                          load_err;

  modport master (
    output ena, set_coeffs, din_valid, din,
    input  coeff_flat, coeff_update, loading, load_err
  );

  modport slave (
    input  ena, set_coeffs, din_valid, din,
    output coeff_flat, coeff_update, loading, load_err
  );
endinterface
`default_nettype wire

// File: rtl/fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_loader
// Purpose  : Captures a coefficient set one beat at a time into a shadow
//            buffer and commits it to the FIR core in a single cycle.
// Revision : 1.0
// ============================================================================
module fir_coeff_loader #(
  parameter int NUM_TAPS = 4,
  parameter int COEFF_W  = 8,
  parameter int TIMEOUT  = 255,
  parameter logic [NUM_TAPS*COEFF_W-1:0] DEFAULT_COEFFS = {NUM_TAPS{8'h40}}
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  fir_coeff_loader_if.slave  bus
);
  localparam int IDX_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int FLAT_W = NUM_TAPS * COEFF_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              set_q;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [FLAT_W-1:0] shadow, shadow_nxt;
  logic [FLAT_W-1:0] coeff, coeff_nxt;
  logic              update, update_nxt;
  logic              err, err_nxt;
  logic              loading_r;

  logic rise, last, tmo;
  assign rise = bus.set_coeffs & ~set_q;
  assign last = (idx == IDX_W'(NUM_TAPS - 1));
  assign tmo  = (timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (bus.ena) begin
      state <= state_nxt;
    end
  end

  // Capture outranks release, release outranks timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (rise) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (bus.din_valid) begin
          if (last) state_nxt = ST_HOLD;
        end else if (!bus.set_coeffs || tmo) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: if (!bus.set_coeffs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_nxt    = idx;
    timer_nxt  = timer;
    shadow_nxt = shadow;
    coeff_nxt  = coeff;
    update_nxt = 1'b0;
    err_nxt    = err;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          idx_nxt   = '0;
          timer_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (bus.din_valid) begin
          shadow_nxt[int'(idx)*COEFF_W +: COEFF_W] = bus.din;
          timer_nxt = '0;
          if (last) begin
            coeff_nxt  = shadow_nxt;
            update_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else if (!bus.set_coeffs || tmo) begin
          err_nxt = 1'b1;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q     <= 1'b0;
      idx       <= '0;
      timer     <= '0;
      shadow    <= '0;
      coeff     <= DEFAULT_COEFFS;
      update    <= 1'b0;
      err       <= 1'b0;
      loading_r <= 1'b0;
    end else if (bus.ena) begin
      set_q     <= bus.set_coeffs;
      idx       <= idx_nxt;
      timer     <= timer_nxt;
      shadow    <= shadow_nxt;
      coeff     <= coeff_nxt;
      update    <= update_nxt;
      err       <= err_nxt;
      loading_r <= (state_nxt == ST_LOAD);
    end
  end

  assign bus.coeff_flat   = coeff;
  assign bus.coeff_update = update;
  assign bus.loading      = loading_r;
  assign bus.load_err     = err;
endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_coeff_loader
// Purpose  : Vector table, corner-case sequences and randomized traffic
//            against a queue-based reference model of the loader.
// Revision : 1.0
// ============================================================================
module tb_fir_coeff_loader;
  localparam int NT = 4;
  localparam int CW = 8;
  localparam int TO = 255;
  localparam int FW = NT * CW;
  localparam logic [FW-1:0] DEF = {NT{8'h40}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_coeff_loader_if #(.NUM_TAPS(NT), .COEFF_W(CW)) bus();

  fir_coeff_loader #(
    .NUM_TAPS(NT), .COEFF_W(CW), .TIMEOUT(TO), .DEFAULT_COEFFS(DEF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [FW-1:0] act, logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: words collected in a queue, idle cycles counted.
  logic [CW-1:0] m_words[$];
  logic [FW-1:0] m_flat;
  bit m_loading, m_wait_release, m_prev_set, m_upd, m_err;
  int m_idle;

  function automatic void model_reset();
    m_words.delete();
    m_flat = DEF;
    m_loading = 0; m_wait_release = 0; m_prev_set = 0;
    m_upd = 0; m_err = 0; m_idle = 0;
  endfunction

  function automatic void model_clock(bit e, bit s, bit v, logic [CW-1:0] d);
    if (!e) return;
    m_upd = 0;
    if (m_loading) begin
      if (v) begin
        m_words.push_back(d);
        m_idle = 0;
        if (m_words.size() == NT) begin
          for (int k = 0; k < NT; k++) m_flat[k*CW +: CW] = m_words[k];
          m_upd = 1;
          m_loading = 0;
          m_wait_release = 1;
        end
      end else if (!s) begin
        m_loading = 0; m_err = 1;
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_loading = 0; m_err = 1;
        end
      end
    end else if (m_wait_release) begin
      if (!s) m_wait_release = 0;
    end else if (s && !m_prev_set) begin
      m_loading = 1;
      m_words.delete();
      m_idle = 0;
      m_err = 0;
    end
    m_prev_set = s;
  endfunction

  task automatic check_model(string tag);
    chk({tag, "_flat"}, bus.coeff_flat, m_flat);
    chk({tag, "_upd"},  FW'(bus.coeff_update), FW'(m_upd));
    chk({tag, "_load"}, FW'(bus.loading), FW'(m_loading));
    chk({tag, "_err"},  FW'(bus.load_err), FW'(m_err));
  endtask

  task automatic step(bit e, bit s, bit v, logic [CW-1:0] d, string tag);
    bus.ena = e; bus.set_coeffs = s; bus.din_valid = v; bus.din = d;
    @(posedge clk);
    model_clock(e, s, v, d);
    #1;
    check_model(tag);
  endtask

  task automatic release_reset();
    bus.ena = 1; bus.set_coeffs = 0; bus.din_valid = 0; bus.din = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_clock(1, 0, 0, '0);
    #1;
  endtask

  typedef struct {
    bit ena; bit set; bit valid; logic [CW-1:0] din;
    logic [FW-1:0] flat; bit upd; bit ld; bit err;
  } vec_t;

  vec_t tbl[20];

  initial begin
    bit s_lvl;
    // Basic load, release, abort on release, rise-cycle data ignored,
    // final beat together with release.
    tbl[0]  = '{1,1,0,8'h00, 32'h40404040,0,1,0};
    tbl[1]  = '{1,1,1,8'h01, 32'h40404040,0,1,0};
    tbl[2]  = '{1,1,1,8'h02, 32'h40404040,0,1,0};
    tbl[3]  = '{1,1,1,8'h03, 32'h40404040,0,1,0};
    tbl[4]  = '{1,1,1,8'h04, 32'h04030201,1,0,0};
    tbl[5]  = '{1,1,0,8'h00, 32'h04030201,0,0,0};
    tbl[6]  = '{1,1,1,8'h55, 32'h04030201,0,0,0};
    tbl[7]  = '{1,0,0,8'h00, 32'h04030201,0,0,0};
    tbl[8]  = '{1,1,0,8'h00, 32'h04030201,0,1,0};
    tbl[9]  = '{1,1,1,8'h11, 32'h04030201,0,1,0};
    tbl[10] = '{1,1,1,8'h22, 32'h04030201,0,1,0};
    tbl[11] = '{1,0,0,8'h00, 32'h04030201,0,0,1};
    tbl[12] = '{1,1,0,8'h00, 32'h04030201,0,1,0};
    tbl[13] = '{1,0,0,8'h00, 32'h04030201,0,0,1};
    tbl[14] = '{1,1,1,8'hEE, 32'h04030201,0,1,0};
    tbl[15] = '{1,1,1,8'hA1, 32'h04030201,0,1,0};
    tbl[16] = '{1,1,1,8'hA2, 32'h04030201,0,1,0};
    tbl[17] = '{1,1,1,8'hA3, 32'h04030201,0,1,0};
    tbl[18] = '{1,0,1,8'hA4, 32'hA4A3A2A1,1,0,0};
    tbl[19] = '{1,0,0,8'h00, 32'hA4A3A2A1,0,0,0};

    bus.ena = 0; bus.set_coeffs = 0; bus.din_valid = 0; bus.din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flat", bus.coeff_flat, 32'h40404040);
    chk("rst_load", FW'(bus.loading), '0);
    chk("rst_err",  FW'(bus.load_err), '0);
    chk("rst_upd",  FW'(bus.coeff_update), '0);
    release_reset();

    for (int i = 0; i < 20; i++) begin
      bus.ena = tbl[i].ena; bus.set_coeffs = tbl[i].set;
      bus.din_valid = tbl[i].valid; bus.din = tbl[i].din;
      @(posedge clk);
      model_clock(tbl[i].ena, tbl[i].set, tbl[i].valid, tbl[i].din);
      #1;
      chk($sformatf("vec%0d_flat", i), bus.coeff_flat, tbl[i].flat);
      chk($sformatf("vec%0d_upd", i),  FW'(bus.coeff_update), FW'(tbl[i].upd));
      chk($sformatf("vec%0d_load", i), FW'(bus.loading), FW'(tbl[i].ld));
      chk($sformatf("vec%0d_err", i),  FW'(bus.load_err), FW'(tbl[i].err));
    end

    // Gapped load
    step(1, 1, 0, '0, "gap_rise");
    for (int w = 0; w < NT; w++) begin
      for (int g = 0; g < 3; g++) step(1, 1, 0, '0, "gap_idle");
      step(1, 1, 1, CW'(8'hAA + 8'h11 * w), "gap_beat");
    end
    chk("gap_flat", bus.coeff_flat, 32'hDDCCBBAA);
    chk("gap_err", FW'(bus.load_err), '0);
    step(1, 0, 0, '0, "gap_rel");

    // Timeout abort, held level must not restart
    step(1, 1, 0, '0, "to_rise");
    step(1, 1, 1, 8'h71, "to_b0");
    step(1, 1, 1, 8'h72, "to_b1");
    for (int i = 0; i < TO - 1; i++) step(1, 1, 0, '0, "to_idle");
    chk("to_still_loading", FW'(bus.loading), FW'(1'b1));
    step(1, 1, 0, '0, "to_expire");
    chk("to_abort_load", FW'(bus.loading), '0);
    chk("to_abort_err", FW'(bus.load_err), FW'(1'b1));
    chk("to_flat_kept", bus.coeff_flat, 32'hDDCCBBAA);
    for (int i = 0; i < 5; i++) step(1, 1, 0, '0, "to_held");
    chk("to_no_restart", FW'(bus.loading), '0);
    step(1, 0, 0, '0, "to_rel");

    // Asynchronous reset mid-load
    step(1, 1, 0, '0, "ar_rise");
    step(1, 1, 1, 8'h91, "ar_b0");
    step(1, 1, 1, 8'h92, "ar_b1");
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flat", bus.coeff_flat, DEF);
    chk("ar_load", FW'(bus.loading), '0);
    chk("ar_err",  FW'(bus.load_err), '0);
    model_reset();
    release_reset();

    // Enable window mid-load freezes progress
    step(1, 1, 0, '0, "en_rise");
    step(1, 1, 1, 8'h31, "en_b0");
    step(1, 1, 1, 8'h32, "en_b1");
    for (int i = 0; i < 4; i++) step(0, 0, 1, CW'($urandom), "en_frozen");
    step(1, 1, 1, 8'h33, "en_b2");
    step(1, 1, 1, 8'h34, "en_b3");
    chk("en_flat", bus.coeff_flat, 32'h34333231);
    chk("en_upd", FW'(bus.coeff_update), FW'(1'b1));
    step(1, 0, 0, '0, "en_rel");

    // Randomized traffic
    s_lvl = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) s_lvl = ~s_lvl;
      step(($urandom_range(0, 9) != 0), s_lvl, $urandom_range(0, 1) == 1,
           CW'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
